// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are latched, applied to the ALU for one cycle, and the registered result is held until accepted.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             grant_vld;
  logic             grant_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Contention is settled by prio; a lone requester always wins.
  always_comb begin
    grant_vld = |req_valid;
    grant_idx = 1'b0;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = prio_q;
      default: grant_idx = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    zero_d    = zero_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready = grant_idx ? 2'b10 : 2'b01;
          owner_d   = grant_idx;
          op_d      = grant_idx ? req_op1 : req_op0;
          a_d       = grant_idx ? req_a1 : req_a0;
          b_d       = grant_idx ? req_b1 : req_b0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_control = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU sits behind the arbiter and a
// scoreboard pairs each accepted request with the response that comes back.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]   req_op0, req_op1, alu_control;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic         rsp_zero, alu_zero, busy, owner;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         port;
    logic [W-1:0] res;
    logic         zero;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a | b;
      4'b0010: alu_fn = a + b;
      4'b0110: alu_fn = a - b;
      default: alu_fn = a ^ b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_control, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: requests are pushed at the handshake, popped at the response handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if ((req_valid & req_ready) != 2'b00) begin
        exp_t e;
        e.port = req_ready[1];
        e.res  = e.port ? alu_fn(req_op1, req_a1, req_b1) : alu_fn(req_op0, req_a0, req_b0);
        e.zero = (e.res == '0);
        sb_q.push_back(e);
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_port", {30'd0, rsp_valid}, e.port ? 32'd2 : 32'd1);
          chk("sb_result", rsp_result, e.res);
          chk("sb_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_control}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    rst = 1'b0;

    // port 0 alone: add 4+2
    req_valid = 2'b01; req_op0 = 4'b0010; req_a0 = 4; req_b0 = 2;
    #1 chk("t1_req_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_alu_ctrl", {28'd0, alu_control}, 32'd2);
    chk("t1_alu_a", alu_a, 32'd4);
    chk("t1_alu_b", alu_b, 32'd2);
    chk("t1_exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    tick();
    chk("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("t1_result", rsp_result, 32'd6);
    chk("t1_zero", {31'd0, rsp_zero}, 32'd0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // port 1 alone: sub 5-5
    req_valid = 2'b10; req_op1 = 4'b0110; req_a1 = 5; req_b1 = 5;
    #1 chk("t2_req_ready", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    chk("t2_owner", {31'd0, owner}, 32'd1);
    tick();
    chk("t2_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    chk("t2_result", rsp_result, 32'd0);
    chk("t2_zero", {31'd0, rsp_zero}, 32'd1);
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00;

    // sustained contention: AND on port 0, OR on port 1, responses always accepted
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_op0 = 4'b0000; req_a0 = 4; req_b0 = 2;
    req_op1 = 4'b0001; req_a1 = 4; req_b1 = 2;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_grant", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("t3_exec_ready", {30'd0, req_ready}, 32'd0);
      tick();
      chk("t3_rsp_valid", {30'd0, rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("t3_result", rsp_result, (i % 2 == 0) ? 32'd0 : 32'd6);
      tick();
    end
    rsp_ready = 2'b00;

    // response backpressure with port 1 waiting
    #1 chk("t4_grant", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {30'd0, rsp_valid}, 32'd1);
      chk("t4_hold_result", rsp_result, 32'd0);
      chk("t4_hold_req_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
    #1 chk("t4_p1_grant", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    tick();
    chk("t4_p1_rsp", {30'd0, rsp_valid}, 32'd2);
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00;

    // serve port 0 so prio moves to 1, then reset during EXEC
    req_valid = 2'b01; req_op0 = 4'b0010; req_a0 = 7; req_b0 = 9;
    tick(); req_valid = 2'b00;
    tick(); rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
    req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    chk("t5_in_exec", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t5_exec_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_exec_rst_rsp", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    #1 chk("t5_exec_rst_prio", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b00;
    tick(); rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;

    // prio is now 1: port 1 wins, then reset in RESP while a handshake is offered
    req_valid = 2'b11; req_op1 = 4'b0110; req_a1 = 3; req_b1 = 10;
    #1 chk("t6_grant", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    tick();
    chk("t6_in_resp", {30'd0, rsp_valid}, 32'd2);
    rst = 1'b1; rsp_ready = 2'b11;
    tick(); rst = 1'b0; rsp_ready = 2'b00;
    chk("t6_resp_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_resp_rst_rsp", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    #1 chk("t6_resp_rst_prio", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b00;
    tick(); rsp_ready = 2'b11;
    tick(); rsp_ready = 2'b00;
    tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
